// File: rtl/mem_pkg.sv
// Shared types and default geometry for the MEM-stage refill / write-through controller.
package mem_pkg;

  localparam int DEF_WORDS = 4;
  localparam int DEF_AW    = 32;
  localparam int DEF_DW    = 32;

  localparam int LINE_W = DEF_WORDS * DEF_DW;
  localparam int OFF_W  = $clog2(DEF_WORDS) + 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    WR_REQ,
    FILL
  } state_t;

endpackage

// File: rtl/mem_refill_ctrl_if.sv
// Word-wide backing-memory port: controller is the master, memory is the slave.
interface mem_refill_ctrl_if #(
  parameter int AW = mem_pkg::DEF_AW,
  parameter int DW = mem_pkg::DEF_DW
);

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/line_assembler.sv
// Word-indexed cache line register; one word is written per enabled cycle.
module line_assembler #(
  parameter int WORDS = mem_pkg::DEF_WORDS,
  parameter int DW    = mem_pkg::DEF_DW,
  localparam int IW   = $clog2(WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IW-1:0]       idx,
  input  logic [DW-1:0]       data,
  output logic [WORDS*DW-1:0] line
);

  logic [DW-1:0] words [WORDS];

  // Each word has its own register so a refill only ever touches the addressed slot.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    always_ff @(posedge clk) begin
      if (rst) begin
        words[gi] <= '0;
      end else if (we && (idx == IW'(gi))) begin
        words[gi] <= data;
      end
    end

    assign line[gi*DW +: DW] = words[gi];
  end

endmodule

// File: rtl/mem_refill_ctrl.sv
// MEM-stage miss/write-through controller: refills a whole line on a read miss,
// writes every store through, and stalls the pipeline while either is in flight.
module mem_refill_ctrl
  import mem_pkg::*;
#(
  parameter int WORDS = DEF_WORDS,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         addr,
  input  logic [DW-1:0]         wdata,
  input  logic                  mr,
  input  logic                  mw,
  input  logic                  miss,
  output logic                  hit,
  output logic                  fill_we,
  output logic [AW-1:0]         fill_addr,
  output logic [WORDS*DW-1:0]   fill_line,
  mem_refill_ctrl_if.master     mem
);

  localparam int CW = $clog2(WORDS);
  localparam int OW = CW + 2;
  localparam logic [CW-1:0] LAST      = CW'(WORDS - 1);
  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);
  localparam logic [AW-1:0] LINE_MASK = ~AW'((1 << OW) - 1);

  state_t        state;
  state_t        next;
  logic [CW-1:0] cnt;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata_q;
  logic          req;
  logic          we;
  logic          rd_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Address/data capture happens only in IDLE, so everything stays frozen during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      fill_addr <= '0;
      waddr     <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mw) begin
            waddr   <= addr & WORD_MASK;
            wdata_q <= wdata;
          end else if (mr && miss) begin
            fill_addr <= addr & LINE_MASK;
            cnt       <= '0;
          end
        end
        RD_REQ: begin
          if (mem.mem_ack) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // A store wins over a simultaneous load; hit drops combinationally in the trigger cycle.
  always_comb begin
    next    = state;
    hit     = 1'b1;
    fill_we = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    case (state)
      IDLE: begin
        if (mw) begin
          next = WR_REQ;
          hit  = 1'b0;
        end else if (mr && miss) begin
          next = RD_REQ;
          hit  = 1'b0;
        end
      end
      RD_REQ: begin
        hit = 1'b0;
        req = 1'b1;
        if (mem.mem_ack && (cnt == LAST)) begin
          next = FILL;
        end
      end
      WR_REQ: begin
        hit = 1'b0;
        req = 1'b1;
        we  = 1'b1;
        if (mem.mem_ack) begin
          next = IDLE;
        end
      end
      FILL: begin
        hit     = 1'b0;
        fill_we = 1'b1;
        next    = IDLE;
      end
      default: begin
        next = IDLE;
      end
    endcase
  end

  assign rd_ack = (state == RD_REQ) && mem.mem_ack;

  assign mem.mem_req   = req;
  assign mem.mem_we    = we;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_addr  = (state == WR_REQ) ? waddr
                                           : {fill_addr[AW-1:OW], cnt, 2'b00};

  line_assembler #(
    .WORDS (WORDS),
    .DW    (DW)
  ) u_line (
    .clk  (clk),
    .rst  (rst),
    .we   (rd_ack),
    .idx  (cnt),
    .data (mem.mem_rdata),
    .line (fill_line)
  );

endmodule

// File: doc/mem_refill_ctrl.md
# mem_refill_ctrl

Miss and write-through controller for the MEM stage. It sits between the data cache and a word-wide backing memory. On a read miss it fetches a full 4-word line over a req/ack handshake, assembles the 128-bit line and writes it into the cache. On every store it performs a single-word write-through. While either operation is in progress it holds the pipeline-wide `hit` low, which freezes PC, all pipeline registers and instruction memory.

## Interface
- `WORDS`, 4: words per cache line; must be a power of two, at least 2.
- `AW`, 32: address width.
- `DW`, 32: data word width; line width is `WORDS*DW`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous and active-high.
- `addr`  in  AW  MEM-stage ALU result, the load/store address.
- `wdata`  in  DW  MEM-stage store data.
- `mr`  in  1  MEM-stage memory read.
- `mw`  in  1  MEM-stage memory write.
- `miss`  in  1  cache tag miss for `addr`; combinational from the cache, same cycle.
- `hit`  out  1  global pipeline advance; 0 = stall all stages.
- `fill_we`  out  1  one-cycle cache line write strobe.
- `fill_addr`  out  AW  line base address: `addr` with offset bits zeroed.
- `fill_line`  out  WORDS*DW  assembled line; word i is at bits [i*DW +: DW].
- `mem_req`  out  1  backing-memory request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  AW  word address; low 2 bits are always 0.
- `mem_wdata`  out  DW  write data.
- `mem_ack`  in  1  single-cycle completion pulse from memory.
- `mem_rdata`  in  DW  read data; valid in the `mem_ack` cycle.

## Operation
- States: IDLE, RD_REQ, WR_REQ, FILL.
- IDLE:
  - `mw` = 1 → WR_REQ. Write-through, no-allocate; the `miss` value is ignored.
  - `mr` = 1 and `miss` = 1 → RD_REQ. Capture the line base address and clear the word counter.
  - Otherwise stay in IDLE.
  - `mr` and `mw` both high is treated as a write.
- RD_REQ:
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = {base[AW-1:4], cnt, 2'b00}.
  - On `mem_ack`: store `mem_rdata` into line word `cnt`, then increment `cnt`.
  - If `cnt` was WORDS-1 → FILL. Otherwise stay in RD_REQ.
- WR_REQ:
  - `mem_req` = 1, `mem_we` = 1; the address and data are registered at entry.
  - On `mem_ack` → IDLE.
- FILL: `fill_we` = 1 for exactly one cycle, then → IDLE. The pipeline repeats the lookup and now hits.
- `hit` = 0 whenever state ≠ IDLE.
- `hit` = 0 in IDLE during a cycle that takes a transition out of IDLE. This path is combinational from `mr`/`mw`/`miss`.
- `hit` = 1 in all other cycles.
- `cnt` is log2(WORDS) bits and wraps to 0 after word WORDS-1.
- The address, data and line registers hold stable while stalled. Inputs are also frozen because `hit` = 0.

## Timing
- Reset values:
  - state = IDLE, `hit` = 1, `fill_we` = 0, `mem_req` = 0, `mem_we` = 0, `cnt` = 0.
  - `mem_addr`, `mem_wdata`, `fill_addr`, `fill_line` = 0.
- Handshake rules:
  - `mem_req` rises the cycle after the triggering IDLE cycle.
  - `mem_req`, `mem_addr` and `mem_we` stay stable until the `mem_ack` cycle.
  - `mem_ack` may arrive in the first `mem_req` cycle (zero wait).
  - Between words, `mem_req` stays high and `mem_addr` advances the cycle after `mem_ack`.
- Read-miss latency with zero-wait memory: 1 (IDLE detect) + WORDS (requests) + 1 (FILL) = 6 stall cycles for WORDS = 4. `hit` returns to 1 in the cycle after FILL.
- Write-through latency: 1 + number of memory wait cycles + 1 ack cycle.
- `mem_ack` while `mem_req` = 0 is ignored, e.g. a late ack after reset.
- `rst` takes priority in any state. The next cycle is IDLE with `mem_req` = 0; a partially assembled line is discarded and `fill_we` is not asserted.

## Structure
- Shared package `mem_pkg`:
  - state enum {IDLE, RD_REQ, WR_REQ, FILL};
  - `LINE_W` = WORDS*DW;
  - `OFF_W` = log2(WORDS) + 2.
- Sub-module `line_assembler`: word-indexed line register with write enable, index and data inputs; it holds `fill_line`.
- The FSM, counter and memory-port registers live in the top of `mem_refill_ctrl`.

## Test plan
- Reset, then IDLE with `mr` = 1, `miss` = 0 → `hit` = 1 every cycle, `mem_req` never rises.
- Read miss at 0x0000_0124, memory acks every cycle with rdata = 0xA0 + word index:
  - `mem_addr` sequence is 0x120, 0x124, 0x128, 0x12C;
  - `fill_addr` = 0x120 and `fill_line` = {0xA3, 0xA2, 0xA1, 0xA0};
  - `fill_we` pulses once, and `hit` is low for exactly 6 cycles.
- Store 0xDEADBEEF to 0x40 with the ack delayed 3 cycles → `mem_we` = 1, address 0x40 held for 4 cycles; `hit` low for 5 cycles; `fill_we` never asserts.
- `mr` = `mw` = 1 with `miss` = 1 → write path only; no read request is issued.
- `rst` asserted after the 2nd ack of a refill, then a stray `mem_ack` one cycle later → state IDLE, `hit` = 1, no `fill_we`, the stray ack is ignored.
- Back-to-back read misses to 0x100 and 0x200 → two complete refills; the second `fill_line` holds no words from the first.
